// File: rtl/vga_mode_sequencer.sv
// Frame-synchronous VGA test-pattern mode sequencer: blank / manual / auto-cycle.
// Optional auto-cycle (AUTO state, auto_req, rotation) is compiled in with `define MODE_SEQ_AUTO_EN.
module vga_mode_sequencer #(
  parameter int FRAME_HOLD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic [5:0] mode_req,
  input  logic       auto_req,
  output logic [5:0] mode_sel,
  output logic       mode_valid,
  output logic       conflict,
  output logic [7:0] frame_count,
  output logic       box_step
);

  if (FRAME_HOLD < 1 || FRAME_HOLD > 256) begin : g_hold_check
    $error("FRAME_HOLD out of range 1..256");
  end

`ifdef MODE_SEQ_AUTO_EN
  typedef enum logic [1:0] {BLANK, MANUAL, AUTO} state_t;
  localparam logic [7:0] HOLD_LAST = 8'(FRAME_HOLD - 1);
`else
  typedef enum logic [1:0] {BLANK, MANUAL} state_t;
  logic unused_auto_req;
  assign unused_auto_req = auto_req;
`endif

  state_t     state, state_nxt;
  logic [5:0] mode_sel_nxt;
  logic       conflict_nxt;
  logic [7:0] count_nxt;
  logic       box_nxt;
  logic       restart;
  logic [2:0] req_cnt;

  function automatic logic [2:0] popcount6(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  assign req_cnt    = popcount6(mode_req);
  assign mode_valid = |mode_sel;

  // Next-state decode: everything is evaluated only on frame_start cycles.
  always_comb begin
    state_nxt    = state;
    mode_sel_nxt = mode_sel;
    conflict_nxt = conflict;
    count_nxt    = frame_count;
    box_nxt      = 1'b0;
    restart      = 1'b0;
    if (frame_start) begin
      if (req_cnt > 3'd1) begin
        state_nxt    = BLANK;
        mode_sel_nxt = 6'b000000;
        conflict_nxt = 1'b1;
      end else if (req_cnt == 3'd1) begin
        state_nxt    = MANUAL;
        mode_sel_nxt = mode_req;
        conflict_nxt = 1'b0;
`ifdef MODE_SEQ_AUTO_EN
      end else if (auto_req) begin
        conflict_nxt = 1'b0;
        state_nxt    = AUTO;
        if (state != AUTO) begin
          mode_sel_nxt = 6'b000001;
          restart      = 1'b1;
        end else if (frame_count == HOLD_LAST) begin
          mode_sel_nxt = {mode_sel[4:0], mode_sel[5]};
        end
`endif
      end else begin
        state_nxt    = BLANK;
        mode_sel_nxt = 6'b000000;
        conflict_nxt = 1'b0;
      end

      // Rotation changes mode_sel, so the mode-change clear also resets the hold counter.
      if (restart || (mode_sel_nxt != mode_sel)) count_nxt = 8'd0;
      else if (frame_count != 8'd255)            count_nxt = frame_count + 8'd1;

      box_nxt = mode_sel_nxt[5];
    end
  end

  // Register stage: all outputs update together on the sampling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BLANK;
      mode_sel    <= 6'b000000;
      conflict    <= 1'b0;
      frame_count <= 8'd0;
      box_step    <= 1'b0;
    end else begin
      state       <= state_nxt;
      mode_sel    <= mode_sel_nxt;
      conflict    <= conflict_nxt;
      frame_count <= count_nxt;
      box_step    <= box_nxt;
    end
  end

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Directed bench for vga_mode_sequencer (FRAME_HOLD=2); auto-cycle steps follow MODE_SEQ_AUTO_EN.
module tb_vga_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic [5:0] mode_req;
  logic       auto_req;
  logic [5:0] mode_sel;
  logic       mode_valid;
  logic       conflict;
  logic [7:0] frame_count;
  logic       box_step;

  int checks   = 0;
  int failures = 0;

  vga_mode_sequencer #(.FRAME_HOLD(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .mode_req    (mode_req),
    .auto_req    (auto_req),
    .mode_sel    (mode_sel),
    .mode_valid  (mode_valid),
    .conflict    (conflict),
    .frame_count (frame_count),
    .box_step    (box_step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns on the falling edge just after the edge that sampled frame_start=1.
  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

`ifdef MODE_SEQ_AUTO_EN
  logic [5:0] exp_seq [13] = '{6'b000001, 6'b000001, 6'b000010, 6'b000010, 6'b000100,
                               6'b000100, 6'b001000, 6'b001000, 6'b010000, 6'b010000,
                               6'b100000, 6'b100000, 6'b000001};
`endif

  initial begin
    rst = 1'b1; frame_start = 1'b0; mode_req = 6'b0; auto_req = 1'b0;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mode_sel", 32'(mode_sel), 32'h00);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_conflict", 32'(conflict), 32'd0);
    chk("rst_mode_valid", 32'(mode_valid), 32'd0);
    chk("rst_box_step", 32'(box_step), 32'd0);

    mode_req = 6'b000100;
    idle(3);
    chk("midframe_no_change", 32'(mode_sel), 32'h00);
    pulse_frame();
    chk("manual_green_sel", 32'(mode_sel), 32'h04);
    chk("manual_green_valid", 32'(mode_valid), 32'd1);
    chk("manual_green_count", 32'(frame_count), 32'd0);
    pulse_frame();
    chk("manual_hold_sel", 32'(mode_sel), 32'h04);
    chk("manual_hold_count", 32'(frame_count), 32'd1);

    mode_req = 6'b010001;
    pulse_frame();
    chk("conflict_sel", 32'(mode_sel), 32'h00);
    chk("conflict_flag", 32'(conflict), 32'd1);
    chk("conflict_valid", 32'(mode_valid), 32'd0);
    chk("conflict_count_clear", 32'(frame_count), 32'd0);
    pulse_frame();
    chk("conflict_hold_flag", 32'(conflict), 32'd1);
    chk("conflict_hold_count", 32'(frame_count), 32'd1);

    mode_req = 6'b100000;
    pulse_frame();
    chk("box_sel", 32'(mode_sel), 32'h20);
    chk("box_conflict_clear", 32'(conflict), 32'd0);
    chk("box_count", 32'(frame_count), 32'd0);
    pulse_frame();
    chk("box_step_pulse1", 32'(box_step), 32'd1);
    chk("box_count_inc", 32'(frame_count), 32'd1);
    @(negedge clk);
    chk("box_step_low", 32'(box_step), 32'd0);
    pulse_frame();
    chk("box_step_pulse2", 32'(box_step), 32'd1);

    mode_req = 6'b000010;
    idle(2);
    chk("box_midframe_hold", 32'(mode_sel), 32'h20);
    pulse_frame();
    chk("red_sel", 32'(mode_sel), 32'h02);
    chk("red_box_step", 32'(box_step), 32'd0);

    @(negedge clk);
    rst = 1'b1; frame_start = 1'b1; mode_req = 6'b000001;
    @(negedge clk);
    rst = 1'b0; frame_start = 1'b0;
    chk("rst_prio_sel", 32'(mode_sel), 32'h00);
    chk("rst_prio_count", 32'(frame_count), 32'd0);

    mode_req = 6'b001000;
    pulse_frame();
    chk("blue_sel", 32'(mode_sel), 32'h08);
    mode_req = 6'b000000;
    pulse_frame();
    chk("idle_blank_sel", 32'(mode_sel), 32'h00);
    chk("idle_blank_conflict", 32'(conflict), 32'd0);

`ifdef MODE_SEQ_AUTO_EN
    auto_req = 1'b1;
    for (int f = 0; f < 13; f++) begin
      pulse_frame();
      chk($sformatf("auto_seq_sel_%0d", f + 1), 32'(mode_sel), 32'(exp_seq[f]));
      chk($sformatf("auto_seq_count_%0d", f + 1), 32'(frame_count), 32'(f % 2));
    end
    pulse_frame();
    pulse_frame();
    chk("auto_pre_rst_sel", 32'(mode_sel), 32'h02);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse_frame();
    chk("auto_reentry_sel", 32'(mode_sel), 32'h01);
    chk("auto_reentry_count", 32'(frame_count), 32'd0);
    pulse_frame();
    pulse_frame();
    chk("auto_rot_sel", 32'(mode_sel), 32'h02);
    mode_req = 6'b001000;
    pulse_frame();
    chk("auto_override_sel", 32'(mode_sel), 32'h08);
    chk("auto_override_count", 32'(frame_count), 32'd0);
`else
    auto_req = 1'b1;
    pulse_frame();
    chk("noauto_blank_sel", 32'(mode_sel), 32'h00);
    chk("noauto_blank_valid", 32'(mode_valid), 32'd0);
    mode_req = 6'b001000;
    pulse_frame();
    chk("manual_over_auto_sel", 32'(mode_sel), 32'h08);
    chk("manual_over_auto_count", 32'(frame_count), 32'd0);
`endif

    for (int f = 0; f < 300; f++) pulse_frame();
    chk("count_saturate", 32'(frame_count), 32'd255);
    chk("count_saturate_sel", 32'(mode_sel), 32'h08);

    mode_req = 6'b000000;
`ifndef MODE_SEQ_AUTO_EN
    pulse_frame();
    chk("noauto_from_manual_sel", 32'(mode_sel), 32'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_mode_sequencer.md
VGA_MODE_SEQUENCER -- requirements
Module: vga_mode_sequencer

Interface
REQ-001 Parameter FRAME_HOLD, default 60, frames spent on each mode in auto-cycle; legal range 1..256.
REQ-002 clk  input  1  pixel clock; all logic is on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 frame_start  input  1  one-cycle pulse when the pixel counter is at (0,0).
REQ-005 mode_req  input  6  level request bits: [0] gradient, [1] red, [2] green, [3] blue, [4] white, [5] box.
REQ-006 auto_req  input  1  level request for auto-cycle through all six modes.
REQ-007 mode_sel  output  6  registered mode select; one-hot or all-zero (blank).
REQ-008 mode_valid  output  1  high when mode_sel is non-zero.
REQ-009 conflict  output  1  high while the sampled mode_req had more than one bit set.
REQ-010 frame_count  output  8  frames elapsed in the current mode; saturates at 255.
REQ-011 box_step  output  1  one-cycle pulse that advances the bouncing box.

Function
REQ-012 States are BLANK, MANUAL and AUTO; the state changes only on a cycle with frame_start=1.
REQ-013 Inputs are sampled only on frame_start cycles; mode_req and auto_req changes between pulses have no effect.
REQ-014 Outputs update on the edge that samples frame_start=1, so they are valid one cycle later.
REQ-015 Popcount(mode_req)>1 goes to BLANK with conflict=1 and mode_sel=0, from any state.
REQ-016 Popcount(mode_req)==1 goes to MANUAL with mode_sel=mode_req and conflict=0; manual always overrides auto_req.
REQ-017 Popcount(mode_req)==0 with auto_req=1 from BLANK/MANUAL enters AUTO with mode_sel=6'b000001 and frame_count=0.
REQ-018 Popcount(mode_req)==0 with auto_req=1 in AUTO increments frame_count on each frame_start.
REQ-019 In AUTO, when frame_count==FRAME_HOLD-1 at a frame_start, mode_sel instead rotates left one bit, wrapping [5] to [0], and frame_count returns to 0.
REQ-020 Popcount(mode_req)==0 with auto_req=0 goes to BLANK with conflict=0.
REQ-021 frame_count clears to 0 whenever mode_sel changes value, increments otherwise, and holds at 255.
REQ-022 box_step pulses on the cycle after a frame_start when the registered mode_sel[5]=1, else 0.
REQ-023 In MANUAL/BLANK, frame_start with unchanged inputs holds state and mode_sel; frame_count still increments (saturating).

Reset
REQ-024 rst=1 forces state BLANK, mode_sel=0, mode_valid=0, conflict=0, frame_count=0 and box_step=0 on the next edge.
REQ-025 rst has priority over frame_start in the same cycle.
REQ-026 Reset mid-AUTO discards rotation position; AUTO re-entry restarts at bit [0].

Configuration
REQ-027 Macro MODE_SEQ_AUTO_EN defined: AUTO state, auto_req and rotation logic are compiled in per REQ-017..019.
REQ-028 Macro MODE_SEQ_AUTO_EN undefined: AUTO state is absent, auto_req is ignored, and popcount 0 always goes to BLANK.

Verification
REQ-029 Apply rst for 2 cycles then release -> mode_sel=0, frame_count=0, conflict=0.
REQ-030 Set mode_req=6'b000100 mid-frame -> no change until the next frame_start; one cycle later mode_sel=6'b000100 and mode_valid=1.
REQ-031 Set mode_req=6'b010001 and pulse frame_start -> mode_sel=0, conflict=1; then set mode_req=6'b100000 and pulse frame_start -> mode_sel=6'b100000, conflict=0, box_step pulses each frame.
REQ-032 With MODE_SEQ_AUTO_EN, FRAME_HOLD=2, auto_req=1, run 13 frame_starts -> sequence 000001,000001,000010,000010,... with 100000 wrapping to 000001 on the 13th.
REQ-033 In AUTO, set mode_req=6'b001000 on a frame_start -> MANUAL 001000 immediately and frame_count=0; keep it for 300 frames -> frame_count=255.
REQ-034 Without the macro, set auto_req=1 and mode_req=0 and pulse frame_start -> mode_sel=0.
